// File: rtl/sram_copy_ctrl.sv
// rtl/sram_copy_ctrl.sv - Wishbone-programmed SRAM-to-SRAM block copy sequencer
// Streams one word per cycle from the source read port to the destination write port.
module sram_copy_ctrl #(
  parameter int WB_ADR_WIDTH  = 8,
  parameter int WB_DAT_WIDTH  = 64,
  parameter int WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
  parameter int MEM_ADR_WIDTH = 10,
  parameter int MEM_DAT_WIDTH = 64,
  parameter logic [WB_DAT_WIDTH-1:0] CORE_ID = 64'h5AA0_5200_0000_0001
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
  output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
  input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
  input  logic                     s_wb_we_i,
  input  logic                     s_wb_stb_i,
  output logic                     s_wb_ack_o,
  output logic                     m_rd_en,
  output logic [MEM_ADR_WIDTH-1:0] m_rd_addr,
  input  logic [MEM_DAT_WIDTH-1:0] m_rd_dout,
  output logic                     m_wr_en,
  output logic [MEM_ADR_WIDTH-1:0] m_wr_addr,
  output logic [MEM_DAT_WIDTH-1:0] m_wr_din,
  output logic                     busy
);
  localparam int LW = MEM_ADR_WIDTH + 1;
  localparam logic [WB_ADR_WIDTH-1:0] REG_ID       = WB_ADR_WIDTH'(0);
  localparam logic [WB_ADR_WIDTH-1:0] REG_CTL      = WB_ADR_WIDTH'(1);
  localparam logic [WB_ADR_WIDTH-1:0] REG_STATUS   = WB_ADR_WIDTH'(2);
  localparam logic [WB_ADR_WIDTH-1:0] REG_SRC      = WB_ADR_WIDTH'(3);
  localparam logic [WB_ADR_WIDTH-1:0] REG_DST      = WB_ADR_WIDTH'(4);
  localparam logic [WB_ADR_WIDTH-1:0] REG_LEN      = WB_ADR_WIDTH'(5);
  localparam logic [WB_ADR_WIDTH-1:0] REG_PROGRESS = WB_ADR_WIDTH'(6);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [MEM_ADR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0]            len_q, len_d, progress_q, progress_d;
  logic                     done_q, done_d, aborted_q, aborted_d;
  logic                     abort_pend_q, abort_pend_d;
  logic [MEM_ADR_WIDTH-1:0] src_cnt_q, src_cnt_d, dst_cnt_q, dst_cnt_d;
  logic [LW-1:0]            rd_left_q, rd_left_d;
  logic                     wr_en_q, wr_en_d;
  logic [MEM_ADR_WIDTH-1:0] wr_addr_q, wr_addr_d;

  logic reg_wr, start_req, abort_req, unused_bits;

  assign reg_wr    = s_wb_stb_i & s_wb_we_i;
  assign start_req = reg_wr && (s_wb_adr_i == REG_CTL) && s_wb_dat_i[0];
  assign abort_req = reg_wr && (s_wb_adr_i == REG_CTL) && s_wb_dat_i[1];
  assign unused_bits = ^{s_wb_dat_i, s_wb_sel_i};

  assign s_wb_ack_o = s_wb_stb_i;
  assign busy       = (state_q != ST_IDLE);
  assign m_rd_en    = (state_q == ST_RUN);
  assign m_rd_addr  = src_cnt_q;
  assign m_wr_en    = wr_en_q;
  assign m_wr_addr  = wr_addr_q;
  assign m_wr_din   = m_rd_dout;

  always_comb begin
    s_wb_dat_o = '0;
    case (s_wb_adr_i)
      REG_ID:       s_wb_dat_o = CORE_ID;
      REG_STATUS:   s_wb_dat_o[2:0] = {aborted_q, done_q, busy};
      REG_SRC:      s_wb_dat_o[MEM_ADR_WIDTH-1:0] = src_q;
      REG_DST:      s_wb_dat_o[MEM_ADR_WIDTH-1:0] = dst_q;
      REG_LEN:      s_wb_dat_o[LW-1:0] = len_q;
      REG_PROGRESS: s_wb_dat_o[LW-1:0] = progress_q;
      default:      s_wb_dat_o = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    src_cnt_d    = src_cnt_q;
    dst_cnt_d    = dst_cnt_q;
    rd_left_d    = rd_left_q;
    progress_d   = progress_q + LW'(wr_en_q);
    wr_en_d      = (state_q == ST_RUN);
    wr_addr_d    = dst_cnt_q;

    if (reg_wr && (s_wb_adr_i == REG_STATUS) && s_wb_dat_i[1]) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end

    // Configuration is frozen while the engine owns the SRAM ports.
    if (reg_wr && (state_q == ST_IDLE)) begin
      for (int i = 0; i < MEM_ADR_WIDTH; i++) begin
        if (s_wb_adr_i == REG_SRC && s_wb_sel_i[i/8]) src_d[i] = s_wb_dat_i[i];
        if (s_wb_adr_i == REG_DST && s_wb_sel_i[i/8]) dst_d[i] = s_wb_dat_i[i];
      end
      for (int i = 0; i < LW; i++) begin
        if (s_wb_adr_i == REG_LEN && s_wb_sel_i[i/8]) len_d[i] = s_wb_dat_i[i];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          aborted_d = 1'b0;
          if (len_q != '0) begin
            state_d      = ST_RUN;
            done_d       = 1'b0;
            abort_pend_d = 1'b0;
            progress_d   = '0;
            src_cnt_d    = src_q;
            dst_cnt_d    = dst_q;
            rd_left_d    = len_q;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        src_cnt_d = src_cnt_q + 1'b1;
        dst_cnt_d = dst_cnt_q + 1'b1;
        rd_left_d = rd_left_q - 1'b1;
        if (abort_req) begin
          abort_pend_d = 1'b1;
          state_d      = ST_DRAIN;
        end else if (rd_left_q == LW'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The single in-flight read is written this cycle.
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        aborted_d = abort_pend_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      src_cnt_q    <= '0;
      dst_cnt_q    <= '0;
      rd_left_q    <= '0;
      progress_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      src_cnt_q    <= src_cnt_d;
      dst_cnt_q    <= dst_cnt_d;
      rd_left_q    <= rd_left_d;
      progress_q   <= progress_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
    end
  end
endmodule

// File: tb/tb_sram_copy_ctrl.sv
// tb/tb_sram_copy_ctrl.sv - randomized self-checking bench for sram_copy_ctrl
// Expected copies are derived from (src+k, dst+k) mod 1024 and start/abort edge numbers.
module tb_sram_copy_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_wb_adr_i = '0;
  logic [63:0] s_wb_dat_o;
  logic [63:0] s_wb_dat_i = '0;
  logic [7:0]  s_wb_sel_i = '0;
  logic        s_wb_we_i = 1'b0;
  logic        s_wb_stb_i = 1'b0;
  logic        s_wb_ack_o;
  logic        m_rd_en;
  logic [9:0]  m_rd_addr;
  logic [63:0] m_rd_dout = '0;
  logic        m_wr_en;
  logic [9:0]  m_wr_addr;
  logic [63:0] m_wr_din;
  logic        busy;

  sram_copy_ctrl dut (
    .reset(reset), .clk(clk),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_o(s_wb_dat_o), .s_wb_dat_i(s_wb_dat_i),
    .s_wb_sel_i(s_wb_sel_i), .s_wb_we_i(s_wb_we_i), .s_wb_stb_i(s_wb_stb_i),
    .s_wb_ack_o(s_wb_ack_o),
    .m_rd_en(m_rd_en), .m_rd_addr(m_rd_addr), .m_rd_dout(m_rd_dout),
    .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr), .m_wr_din(m_wr_din),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [63:0] data;
  } ev_t;

  logic [63:0] src_mem [1024];
  ev_t         rd_log[$];
  ev_t         wr_log[$];
  int          cyc = 0;
  int          busy_cnt = 0;
  int          n_checks = 0;
  int          n_bad = 0;
  logic        pend_en = 1'b0;
  logic [9:0]  pend_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous source SRAM: data appears one cycle after the read request.
  always @(posedge clk) m_rd_dout <= pend_en ? src_mem[pend_addr] : {$urandom, $urandom};

  always @(negedge clk) begin
    pend_en   = m_rd_en;
    pend_addr = m_rd_addr;
    if (m_rd_en) rd_log.push_back('{cyc, m_rd_addr, 64'd0});
    if (m_wr_en) wr_log.push_back('{cyc, m_wr_addr, m_wr_din});
    if (busy) busy_cnt++;
  end

  task automatic wb_write(input int idx, input logic [63:0] d, input logic [7:0] sel, output int ecyc);
    @(negedge clk);
    s_wb_adr_i = 8'(idx);
    s_wb_dat_i = d;
    s_wb_sel_i = sel;
    s_wb_we_i  = 1'b1;
    s_wb_stb_i = 1'b1;
    @(posedge clk);
    #1;
    ecyc = cyc;
    s_wb_we_i  = 1'b0;
    s_wb_stb_i = 1'b0;
  endtask

  task automatic wb_read(input int idx, output logic [63:0] d, output logic ack);
    @(negedge clk);
    s_wb_adr_i = 8'(idx);
    s_wb_we_i  = 1'b0;
    s_wb_stb_i = 1'b1;
    #1;
    d   = s_wb_dat_o;
    ack = s_wb_ack_o;
    s_wb_stb_i = 1'b0;
  endtask

  task automatic run_copy(input int src, input int dst, input int len, input bit do_abort);
    int t, a, e, n, guard, m;
    logic [63:0] v;
    logic ack;
    rd_log.delete();
    wr_log.delete();
    wb_write(3, 64'(src), 8'hFF, e);
    wb_write(4, 64'(dst), 8'hFF, e);
    wb_write(5, 64'(len), 8'hFF, e);
    wb_write(1, 64'h1, 8'hFF, t);
    busy_cnt = 0;
    a = 0;
    if (do_abort) begin
      wb_write(5, 64'd7, 8'hFF, e);
      wb_write(1, 64'h1, 8'hFF, e);
      wb_write(1, 64'h2, 8'hFF, a);
    end
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (busy && guard < 5000);
    chk("done_in_time", 64'(guard < 5000), 64'd1);
    n = len;
    if (do_abort && (a - t) < len) n = a - t;
    chk("rd_count", 64'(rd_log.size()), 64'(n));
    chk("wr_count", 64'(wr_log.size()), 64'(n));
    chk("busy_cycles", 64'(busy_cnt), 64'(n + 1));
    m = (rd_log.size() < n) ? rd_log.size() : n;
    for (int k = 0; k < m; k++) begin
      chk("rd_addr", 64'(rd_log[k].addr), 64'((src + k) % 1024));
      chk("rd_cycle", 64'(rd_log[k].cyc), 64'(t + k));
    end
    m = (wr_log.size() < n) ? wr_log.size() : n;
    for (int k = 0; k < m; k++) begin
      chk("wr_addr", 64'(wr_log[k].addr), 64'((dst + k) % 1024));
      chk("wr_cycle", 64'(wr_log[k].cyc), 64'(t + 1 + k));
      chk("wr_data", wr_log[k].data, src_mem[(src + k) % 1024]);
    end
    wb_read(2, v, ack);
    chk("status", v, do_abort ? 64'b110 : 64'b010);
    wb_read(6, v, ack);
    chk("progress", v, 64'(n));
    wb_read(5, v, ack);
    chk("len_kept", v, 64'(len));
  endtask

  initial begin
    logic [63:0] v;
    logic ack;
    int e, r, t, nw;
    for (int i = 0; i < 1024; i++) src_mem[i] = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_rd_en", 64'(m_rd_en), 64'd0);
    chk("rst_wr_en", 64'(m_wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack_idle", 64'(s_wb_ack_o), 64'd0);
    wb_read(0, v, ack);
    chk("id", v, 64'h5AA0_5200_0000_0001);
    chk("id_ack", 64'(ack), 64'd1);
    wb_read(2, v, ack);
    chk("rst_status", v, 64'd0);
    wb_read(6, v, ack);
    chk("rst_progress", v, 64'd0);

    wb_write(3, 64'h2AB, 8'hFF, e);
    wb_write(3, 64'hFFFF_FFFF_FFFF_FF55, 8'h01, e);
    wb_read(3, v, ack);
    chk("src_lane0", v, 64'h255);
    wb_write(3, 64'h0100, 8'h02, e);
    wb_read(3, v, ack);
    chk("src_lane1", v, 64'h155);
    wb_write(5, 64'hFFFF, 8'hFF, e);
    wb_read(5, v, ack);
    chk("len_width", v, 64'h7FF);
    wb_write(7, 64'hDEAD, 8'hFF, e);
    wb_read(7, v, ack);
    chk("undef_idx", v, 64'd0);
    wb_read(1, v, ack);
    chk("ctl_reads0", v, 64'd0);

    run_copy(12'h010, 12'h200, 4, 1'b0);
    run_copy(12'h3FE, 12'h3FF, 3, 1'b0);

    wb_write(2, 64'h2, 8'hFF, e);
    wb_read(2, v, ack);
    chk("status_w1c", v, 64'd0);
    rd_log.delete();
    wr_log.delete();
    wb_write(5, 64'd0, 8'hFF, e);
    wb_write(1, 64'h1, 8'hFF, e);
    wb_read(2, v, ack);
    chk("len0_status", v, 64'b010);
    repeat (4) @(negedge clk);
    chk("len0_no_rd", 64'(rd_log.size()), 64'd0);
    chk("len0_no_wr", 64'(wr_log.size()), 64'd0);

    run_copy($urandom_range(0, 1023), $urandom_range(0, 1023), 100, 1'b1);
    wb_write(2, 64'h2, 8'hFF, e);
    wb_write(1, 64'h2, 8'hFF, e);
    wb_read(2, v, ack);
    chk("abort_idle_ignored", v, 64'd0);

    for (int i = 0; i < 4; i++)
      run_copy($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(1, 40), 1'b0);

    wb_write(3, 64'h123, 8'hFF, e);
    wb_write(4, 64'h321, 8'hFF, e);
    wb_write(5, 64'd50, 8'hFF, e);
    wb_write(1, 64'h1, 8'hFF, t);
    repeat (10) @(negedge clk);
    wr_log.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    r = cyc;
    reset = 1'b0;
    chk("mid_rst_rd_en", 64'(m_rd_en), 64'd0);
    chk("mid_rst_wr_en", 64'(m_wr_en), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    for (int i = 2; i <= 6; i++) begin
      wb_read(i, v, ack);
      chk($sformatf("mid_rst_reg%0d", i), v, 64'd0);
    end
    nw = 0;
    foreach (wr_log[k]) if (wr_log[k].cyc >= r) nw++;
    chk("mid_rst_no_wr", 64'(nw), 64'd0);
    run_copy($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(1, 40), 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
